// File: rtl/timer_compare_counter_pkg.sv
// timer_pkg: shared definitions for the timer blocks.
//   state_t             - timer control state (IDLE/RUN/DONE, 2-bit encoded)
//   DEFAULT_WIDTH       - default counter / compare width
//   DEFAULT_PRESC_WIDTH - default prescaler divider width
//   RESET_COMPARE       - compare value loaded at reset (all ones)
package timer_pkg;

  localparam int unsigned DEFAULT_WIDTH       = 8;
  localparam int unsigned DEFAULT_PRESC_WIDTH = 16;

  localparam logic [DEFAULT_WIDTH-1:0] RESET_COMPARE = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: programmable clock-enable generator.
//   iClk, iReset  - clock, synchronous active-high reset
//   iEnable       - count while high, hold while low
//   iPrescaleDiv  - tick once every iPrescaleDiv+1 enabled clocks (sampled live)
//   oTick         - combinational tick, high on the last prescaler count
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int unsigned PRESC_WIDTH = DEFAULT_PRESC_WIDTH
) (
  input  logic                   iClk,
  input  logic                   iReset,
  input  logic                   iEnable,
  input  logic [PRESC_WIDTH-1:0] iPrescaleDiv,
  output logic                   oTick
);

  logic [PRESC_WIDTH-1:0] presc;

  assign oTick = iEnable && (presc == iPrescaleDiv);

  // If the divider is lowered below the current count, the plain increment
  // runs on to all-ones and wraps to zero, so the prescaler never locks up.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      presc <= '0;
    end else if (iEnable) begin
      if (oTick) presc <= '0;
      else       presc <= presc + 1'b1;
    end
  end

endmodule

// File: rtl/timer_compare_counter.sv
// timer_compare_counter: prescaled free-running counter with buffered compare.
//   iClk, iReset     - clock, synchronous active-high reset
//   iEnable          - 1 = count, 0 = pause (IDLE) / leave DONE
//   iOneShot         - stop in DONE after the next match
//   iLoadCompare     - strobe: capture iCompareValue into the shadow register
//   iCompareValue    - new compare value
//   iPrescaleDiv     - counter advances every iPrescaleDiv+1 clocks
//   oCount           - current counter value
//   oComparisonTrue  - registered one-cycle pulse per compare match
//   oRunning         - high while in RUN
module timer_compare_counter
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH       = DEFAULT_WIDTH,
  parameter int unsigned PRESC_WIDTH = DEFAULT_PRESC_WIDTH
) (
  input  logic                   iClk,
  input  logic                   iReset,
  input  logic                   iEnable,
  input  logic                   iOneShot,
  input  logic                   iLoadCompare,
  input  logic [WIDTH-1:0]       iCompareValue,
  input  logic [PRESC_WIDTH-1:0] iPrescaleDiv,
  output logic [WIDTH-1:0]       oCount,
  output logic                   oComparisonTrue,
  output logic                   oRunning
);

  state_t           state;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] active;
  logic [WIDTH-1:0] shadow_next;
  logic             cmp_true;
  logic             run_en;
  logic             tick;
  logic             match;

  // Counting stops on the same edge iEnable drops, so a pause holds the
  // value seen before it.
  assign run_en = (state == RUN) && iEnable;

  timer_prescaler #(
    .PRESC_WIDTH(PRESC_WIDTH)
  ) u_prescaler (
    .iClk        (iClk),
    .iReset      (iReset),
    .iEnable     (run_en),
    .iPrescaleDiv(iPrescaleDiv),
    .oTick       (tick)
  );

  // A load on a match cycle bypasses the shadow straight into active.
  assign shadow_next = iLoadCompare ? iCompareValue : shadow;
  assign match       = tick && (count == active);

  always_ff @(posedge iClk) begin
    if (iReset) begin
      state    <= IDLE;
      count    <= '0;
      cmp_true <= 1'b0;
      shadow   <= '1;
      active   <= '1;
    end else begin
      cmp_true <= match;
      shadow   <= shadow_next;
      if (match || (state != RUN)) active <= shadow_next;

      case (state)
        IDLE: begin
          if (iEnable) state <= RUN;
        end
        RUN: begin
          if (!iEnable) begin
            state <= IDLE;
          end else if (tick) begin
            if (match) begin
              count <= '0;
              if (iOneShot) state <= DONE;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        DONE: begin
          count <= '0;
          if (!iEnable) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign oCount          = count;
  assign oComparisonTrue = cmp_true;
  assign oRunning        = (state == RUN);

endmodule

// File: tb/tb_timer_compare_counter.sv
module tb_timer_compare_counter;

  localparam int unsigned WIDTH       = 8;
  localparam int unsigned PRESC_WIDTH = 16;

  logic                   clk;
  logic                   rst;
  logic                   enable;
  logic                   one_shot;
  logic                   load;
  logic [WIDTH-1:0]       cmp_value;
  logic [PRESC_WIDTH-1:0] div;
  logic [WIDTH-1:0]       count;
  logic                   pulse;
  logic                   running;

  int tests;
  int fails;

  timer_compare_counter #(
    .WIDTH      (WIDTH),
    .PRESC_WIDTH(PRESC_WIDTH)
  ) dut (
    .iClk           (clk),
    .iReset         (rst),
    .iEnable        (enable),
    .iOneShot       (one_shot),
    .iLoadCompare   (load),
    .iCompareValue  (cmp_value),
    .iPrescaleDiv   (div),
    .oCount         (count),
    .oComparisonTrue(pulse),
    .oRunning       (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; one_shot = 1'b0; load = 1'b0;
    cmp_value = '0; div = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Load a compare value in IDLE, then raise iEnable.
  task automatic setup_run(input logic [WIDTH-1:0] v, input logic [PRESC_WIDTH-1:0] d, input logic os);
    load = 1'b1; cmp_value = v; div = d; one_shot = os;
    @(negedge clk);
    load = 1'b0; enable = 1'b1;
  endtask

  task automatic wait_count(input logic [WIDTH-1:0] v, input int budget);
    int n;
    n = 0;
    while (count !== v && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (count !== v) begin
      tests++; fails++;
      $display("FAIL wait_count: count=%0d never reached %0d", count, v);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; load = 1'b1; cmp_value = 8'd9; div = '0; one_shot = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (count !== 8'd0 || pulse !== 1'b0 || running !== 1'b0) begin
      fails++;
      $display("FAIL reset_hold: count=%0d pulse=%b run=%b want 0/0/0", count, pulse, running);
    end
    rst = 1'b0; enable = 1'b0; load = 1'b0;
    @(negedge clk);
    tests++;
    if (pulse !== 1'b0 || running !== 1'b0 || count !== 8'd0) begin
      fails++;
      $display("FAIL reset_after: count=%0d pulse=%b run=%b want 0/0/0", count, pulse, running);
    end
  endtask

  task automatic test_continuous();
    logic [WIDTH-1:0] ec;
    logic ep;
    do_reset();
    setup_run(8'd3, 16'd0, 1'b0);
    for (int e = 1; e <= 13; e++) begin
      @(negedge clk);
      ec = (e == 1) ? 8'd0 : 8'((e - 1) % 4);
      ep = (e > 1) && ((e - 1) % 4 == 0);
      tests++;
      if (count !== ec || pulse !== ep || running !== 1'b1) begin
        fails++;
        $display("FAIL continuous e=%0d: count=%0d pulse=%b run=%b want %0d/%b/1", e, count, pulse, running, ec, ep);
      end
    end
  endtask

  task automatic test_prescale();
    logic [WIDTH-1:0] ec;
    logic ep;
    int t;
    do_reset();
    setup_run(8'd1, 16'd2, 1'b0);
    for (int e = 1; e <= 20; e++) begin
      @(negedge clk);
      t  = (e - 1) / 3;
      ec = 8'(t % 2);
      ep = (t > 0) && (t % 2 == 0) && ((e - 1) % 3 == 0);
      tests++;
      if (count !== ec || pulse !== ep) begin
        fails++;
        $display("FAIL prescale e=%0d: count=%0d pulse=%b want %0d/%b", e, count, pulse, ec, ep);
      end
    end
  endtask

  task automatic test_one_shot();
    logic [WIDTH-1:0] ec;
    logic ep, er;
    do_reset();
    setup_run(8'd5, 16'd0, 1'b1);
    for (int e = 1; e <= 12; e++) begin
      @(negedge clk);
      ec = (e == 1) ? 8'd0 : (e <= 6) ? 8'(e - 1) : 8'd0;
      ep = (e == 7);
      er = (e < 7);
      tests++;
      if (count !== ec || pulse !== ep || running !== er) begin
        fails++;
        $display("FAIL one_shot e=%0d: count=%0d pulse=%b run=%b want %0d/%b/%b", e, count, pulse, running, ec, ep, er);
      end
    end
    enable = 1'b0;
    @(negedge clk);
    tests++;
    if (running !== 1'b0 || pulse !== 1'b0) begin
      fails++;
      $display("FAIL one_shot_idle: run=%b pulse=%b want 0/0", running, pulse);
    end
    enable = 1'b1;
    for (int r = 1; r <= 9; r++) begin
      @(negedge clk);
      ec = (r == 1) ? 8'd0 : (r <= 6) ? 8'(r - 1) : 8'd0;
      ep = (r == 7);
      tests++;
      if (count !== ec || pulse !== ep) begin
        fails++;
        $display("FAIL one_shot_rearm r=%0d: count=%0d pulse=%b want %0d/%b", r, count, pulse, ec, ep);
      end
    end
  endtask

  task automatic test_shadow_lower();
    logic [WIDTH-1:0] ec;
    logic ep;
    do_reset();
    setup_run(8'd200, 16'd0, 1'b0);
    wait_count(8'd50, 100);
    load = 1'b1; cmp_value = 8'd10;
    for (int k = 1; k <= 151; k++) begin
      @(negedge clk);
      load = 1'b0;
      ec = (k == 151) ? 8'd0 : 8'(50 + k);
      ep = (k == 151);
      tests++;
      if (count !== ec || pulse !== ep) begin
        fails++;
        $display("FAIL shadow_lower k=%0d: count=%0d pulse=%b want %0d/%b", k, count, pulse, ec, ep);
      end
    end
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      ec = (k == 11) ? 8'd0 : 8'(k);
      ep = (k == 11);
      tests++;
      if (count !== ec || pulse !== ep) begin
        fails++;
        $display("FAIL shadow_new k=%0d: count=%0d pulse=%b want %0d/%b", k, count, pulse, ec, ep);
      end
    end
  endtask

  task automatic test_pause();
    do_reset();
    setup_run(8'd20, 16'd0, 1'b0);
    wait_count(8'd7, 50);
    enable = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      tests++;
      if (count !== 8'd7 || pulse !== 1'b0 || running !== 1'b0) begin
        fails++;
        $display("FAIL pause k=%0d: count=%0d pulse=%b run=%b want 7/0/0", k, count, pulse, running);
      end
    end
    enable = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      tests++;
      if (count !== 8'(6 + k) || running !== 1'b1) begin
        fails++;
        $display("FAIL resume k=%0d: count=%0d run=%b want %0d/1", k, count, running, 6 + k);
      end
    end
  endtask

  task automatic test_load_on_match();
    logic [WIDTH-1:0] ec;
    logic ep;
    do_reset();
    setup_run(8'd3, 16'd0, 1'b0);
    wait_count(8'd3, 50);
    load = 1'b1; cmp_value = 8'd6;
    @(negedge clk);
    load = 1'b0;
    tests++;
    if (count !== 8'd0 || pulse !== 1'b1) begin
      fails++;
      $display("FAIL load_match_edge: count=%0d pulse=%b want 0/1", count, pulse);
    end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      ec = (k == 7) ? 8'd0 : (k == 8) ? 8'd1 : 8'(k);
      ep = (k == 7);
      tests++;
      if (count !== ec || pulse !== ep) begin
        fails++;
        $display("FAIL load_match k=%0d: count=%0d pulse=%b want %0d/%b", k, count, pulse, ec, ep);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [WIDTH-1:0] ec;
    logic ep;
    do_reset();
    setup_run(8'd10, 16'd2, 1'b0);
    wait_count(8'd2, 50);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (count !== 8'd0 || pulse !== 1'b0 || running !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: count=%0d pulse=%b run=%b want 0/0/0", count, pulse, running);
    end
    rst = 1'b0; div = '0;
    // Reset compare is 255: the first pulse comes after a full wrap.
    for (int e = 1; e <= 258; e++) begin
      @(negedge clk);
      ec = (e == 257) ? 8'd0 : (e == 258) ? 8'd1 : 8'(e - 1);
      ep = (e == 257);
      tests++;
      if (count !== ec || pulse !== ep) begin
        fails++;
        $display("FAIL reset_cmp255 e=%0d: count=%0d pulse=%b want %0d/%b", e, count, pulse, ec, ep);
      end
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    rst = 1'b1; enable = 1'b0; one_shot = 1'b0; load = 1'b0;
    cmp_value = '0; div = '0;
    @(negedge clk);
    test_reset();
    test_continuous();
    test_prescale();
    test_one_shot();
    test_shadow_lower();
    test_pause();
    test_load_on_match();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
